writeback_arb_l6: RTL and testbench

WRITEBACK_ARB_L6 -- requirements
Module: writeback_arb_l6

---
 rtl/writeback_arb_l6_pkg.sv | 16 +
 rtl/writeback_arb_l6_rr_arb.sv | 24 ++
 rtl/writeback_arb_l6.sv | 134 +++++++++++++
 tb/tb_writeback_arb_l6.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arb_l6_pkg.sv
// Shared writeback field types: data word, architectural register index and the
// rule that decides whether a completion actually writes the register file.
package writeback_arb_l6_pkg;

    localparam int WB_XLEN      = 32;
    localparam int WB_AREG_BITS = 5;

    typedef logic [WB_XLEN-1:0]      wb_word_t;
    typedef logic [WB_AREG_BITS-1:0] wb_areg_t;

    // x0 is hardwired zero, so writes to it never reach the physical file
    function automatic logic wb_writes_rf(input logic wen, input wb_areg_t waddr);
        return wen && (waddr != '0);
    endfunction

endpackage

// File: rtl/writeback_arb_l6_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr,
// wrapping; no grant when en is low.
module rr_arb #(
    parameter int p_width    = 4,
    parameter int p_ptr_bits = (p_width > 1) ? $clog2(p_width) : 1
) (
    input  logic [p_width-1:0]    req,
    input  logic [p_ptr_bits-1:0] ptr,
    input  logic                  en,
    output logic [p_width-1:0]    gnt
);

    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        for (int k = 0; k < p_width; k++) begin
            idx = (int'(ptr) + k) % p_width;
            if (en && (gnt == '0) && req[idx[p_ptr_bits-1:0]])
                gnt[idx[p_ptr_bits-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/writeback_arb_l6.sv
// Writeback arbiter: picks one execute pipe per cycle round-robin, registers its
// result as a completion for commit and drives the physical register-file write.
module writeback_arb_l6
    import writeback_arb_l6_pkg::*;
#(
    parameter int p_num_pipes      = 4,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [p_num_pipes-1:0]                            ex_val,
    output logic [p_num_pipes-1:0]                            ex_rdy,
    input  logic [p_num_pipes-1:0][WB_XLEN-1:0]               ex_pc,
    input  logic [p_num_pipes-1:0][WB_XLEN-1:0]               ex_wdata,
    input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]        ex_seq_num,
    input  logic [p_num_pipes-1:0][WB_AREG_BITS-1:0]          ex_waddr,
    input  logic [p_num_pipes-1:0]                            ex_wen,
    input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]      ex_preg,
    input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]      ex_ppreg,
    output logic                                              rf_wen,
    output logic [p_phys_addr_bits-1:0]                       rf_waddr,
    output logic [WB_XLEN-1:0]                                rf_wdata,
    output logic                                              cmt_val,
    output logic [WB_XLEN-1:0]                                cmt_pc,
    output logic [p_seq_num_bits-1:0]                         cmt_seq_num,
    output logic [WB_AREG_BITS-1:0]                           cmt_waddr,
    output logic                                              cmt_wen,
    output logic [WB_XLEN-1:0]                                cmt_wdata,
    output logic [p_phys_addr_bits-1:0]                       cmt_preg,
    output logic [p_phys_addr_bits-1:0]                       cmt_ppreg,
    input  logic                                              cmt_rdy
);

    localparam int PTR_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

    typedef struct packed {
        logic                        val;
        wb_word_t                    pc;
        logic [p_seq_num_bits-1:0]   seq;
        wb_areg_t                    waddr;
        logic                        wen;
        wb_word_t                    wdata;
        logic [p_phys_addr_bits-1:0] preg;
        logic [p_phys_addr_bits-1:0] ppreg;
        logic [PTR_W-1:0]            pipe;
    } cmt_t;

    cmt_t                   out_q, out_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [p_num_pipes-1:0] gnt;
    logic [PTR_W-1:0]       gidx;
    logic                   advance;

    assign advance = !out_q.val || cmt_rdy;

    // Grant depends only on valids, pointer and the output handshake
    rr_arb #(
        .p_width   (p_num_pipes),
        .p_ptr_bits(PTR_W)
    ) u_rr_arb (
        .req(ex_val),
        .ptr(ptr_q),
        .en (advance && !rst),
        .gnt(gnt)
    );

    assign ex_rdy = gnt;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < p_num_pipes; i++)
            if (gnt[i]) gidx = PTR_W'(i);
    end

    always_comb begin
        out_d = out_q;
        ptr_d = ptr_q;
        if (advance) begin
            out_d.val = |gnt;
            if (|gnt) begin
                out_d.pc    = ex_pc[gidx];
                out_d.seq   = ex_seq_num[gidx];
                out_d.waddr = ex_waddr[gidx];
                out_d.wen   = ex_wen[gidx];
                out_d.wdata = ex_wdata[gidx];
                out_d.preg  = ex_preg[gidx];
                out_d.ppreg = ex_ppreg[gidx];
                out_d.pipe  = gidx;
                ptr_d       = (gidx == PTR_W'(p_num_pipes - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            ptr_q <= '0;
        end else begin
            out_q <= out_d;
            ptr_q <= ptr_d;
        end
    end

    // A held completion must not leak out while reset is being applied
    assign cmt_val     = out_q.val && !rst;
    assign cmt_pc      = out_q.pc;
    assign cmt_seq_num = out_q.seq;
    assign cmt_waddr   = out_q.waddr;
    assign cmt_wen     = out_q.wen;
    assign cmt_wdata   = out_q.wdata;
    assign cmt_preg    = out_q.preg;
    assign cmt_ppreg   = out_q.ppreg;

    assign rf_wen   = cmt_val && cmt_rdy && wb_writes_rf(cmt_wen, cmt_waddr);
    assign rf_waddr = cmt_preg;
    assign rf_wdata = cmt_wdata;

    // Fixed-width trace column; blank when no completion transfers this cycle
    function automatic string trace(input int trace_level);
        string s, b;
        if (trace_level == 0)
            s = $sformatf("%h", out_q.seq);
        else
            s = $sformatf("%h p%h x%h %h", out_q.seq, out_q.pipe, out_q.waddr, out_q.wdata);
        if (!(cmt_val && cmt_rdy)) begin
            b = "";
            for (int i = 0; i < s.len(); i++) b = {b, " "};
            s = b;
        end
        return s;
    endfunction

endmodule

// File: tb/tb_writeback_arb_l6.sv
// Randomized bench for writeback_arb_l6 against a transaction-level model of the
// round-robin grant and the single completion slot.
module tb_writeback_arb_l6;

    localparam int N  = 4;
    localparam int SB = 5;
    localparam int PB = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       ex_val = '0;
    logic [N-1:0]       ex_rdy;
    logic [N-1:0][31:0] ex_pc, ex_wdata;
    logic [N-1:0][SB-1:0] ex_seq_num;
    logic [N-1:0][4:0]  ex_waddr;
    logic [N-1:0]       ex_wen;
    logic [N-1:0][PB-1:0] ex_preg, ex_ppreg;
    logic               rf_wen;
    logic [PB-1:0]      rf_waddr;
    logic [31:0]        rf_wdata;
    logic               cmt_val;
    logic [31:0]        cmt_pc;
    logic [SB-1:0]      cmt_seq_num;
    logic [4:0]         cmt_waddr;
    logic               cmt_wen;
    logic [31:0]        cmt_wdata;
    logic [PB-1:0]      cmt_preg, cmt_ppreg;
    logic               cmt_rdy = 1'b0;

    always #5 clk = ~clk;

    writeback_arb_l6 #(.p_num_pipes(N), .p_seq_num_bits(SB), .p_phys_addr_bits(PB)) dut (
        .clk(clk), .rst(rst),
        .ex_val(ex_val), .ex_rdy(ex_rdy), .ex_pc(ex_pc), .ex_wdata(ex_wdata),
        .ex_seq_num(ex_seq_num), .ex_waddr(ex_waddr), .ex_wen(ex_wen),
        .ex_preg(ex_preg), .ex_ppreg(ex_ppreg),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .cmt_val(cmt_val), .cmt_pc(cmt_pc), .cmt_seq_num(cmt_seq_num),
        .cmt_waddr(cmt_waddr), .cmt_wen(cmt_wen), .cmt_wdata(cmt_wdata),
        .cmt_preg(cmt_preg), .cmt_ppreg(cmt_ppreg), .cmt_rdy(cmt_rdy)
    );

    typedef struct {
        logic [31:0]   pc, wdata;
        logic [SB-1:0] seq;
        logic [4:0]    waddr;
        logic          wen;
        logic [PB-1:0] preg, ppreg;
    } rec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_val   = 0;
    int   m_ptr   = 0;
    rec_t m_rec;
    bit   hold_fields = 0;
    int   n_grants [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            ex_pc[i]      = $urandom;
            ex_wdata[i]   = $urandom;
            ex_seq_num[i] = SB'($urandom);
            ex_waddr[i]   = 5'($urandom_range(0, 31));
            ex_wen[i]     = 1'($urandom_range(0, 1));
            ex_preg[i]    = PB'($urandom);
            ex_ppreg[i]   = PB'($urandom);
        end
    endtask

    // One clock: drive, check outputs against the model, then advance the model
    task automatic step(input logic [N-1:0] v, input logic r);
        int g;
        bit adv;
        @(negedge clk);
        rst     = 1'b0;
        ex_val  = v;
        cmt_rdy = r;
        if (!hold_fields) rand_fields();
        #1;
        adv = !m_val || r;
        g = -1;
        if (adv)
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        chk("ex_rdy", 64'(ex_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("cmt_val", 64'(cmt_val), 64'(m_val));
        if (m_val) begin
            chk("cmt_pc",    64'(cmt_pc),      64'(m_rec.pc));
            chk("cmt_seq",   64'(cmt_seq_num), 64'(m_rec.seq));
            chk("cmt_waddr", 64'(cmt_waddr),   64'(m_rec.waddr));
            chk("cmt_wen",   64'(cmt_wen),     64'(m_rec.wen));
            chk("cmt_wdata", 64'(cmt_wdata),   64'(m_rec.wdata));
            chk("cmt_preg",  64'(cmt_preg),    64'(m_rec.preg));
            chk("cmt_ppreg", 64'(cmt_ppreg),   64'(m_rec.ppreg));
            chk("rf_wen",    64'(rf_wen),      64'(r && m_rec.wen && m_rec.waddr != 0));
            chk("rf_waddr",  64'(rf_waddr),    64'(m_rec.preg));
            chk("rf_wdata",  64'(rf_wdata),    64'(m_rec.wdata));
        end else begin
            chk("rf_wen_idle", 64'(rf_wen), 64'd0);
        end
        if (adv) begin
            m_val = (g >= 0);
            if (g >= 0) begin
                m_rec = '{pc: ex_pc[g], wdata: ex_wdata[g], seq: ex_seq_num[g],
                          waddr: ex_waddr[g], wen: ex_wen[g], preg: ex_preg[g],
                          ppreg: ex_ppreg[g]};
                m_ptr = (g + 1) % N;
                n_grants[g]++;
            end
        end
    endtask

    task automatic do_reset(input int cyc);
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk);
            rst     = 1'b1;
            ex_val  = N'($urandom);
            cmt_rdy = 1'($urandom);
            #1;
            chk("rst_ex_rdy",  64'(ex_rdy),  64'd0);
            chk("rst_cmt_val", 64'(cmt_val), 64'd0);
            chk("rst_rf_wen",  64'(rf_wen),  64'd0);
        end
        m_val = 0;
        m_ptr = 0;
    endtask

    initial begin
        rand_fields();
        do_reset(2);

        // All pipes valid from empty: strict 0,1,2,3 order
        for (int c = 0; c < 4; c++) step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);

        // Pipe 2 alone writes x5 -> p17
        hold_fields = 1;
        ex_wen[2] = 1'b1; ex_waddr[2] = 5'd5; ex_preg[2] = 6'd17; ex_wdata[2] = 32'hDEADBEEF;
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        chk("dir_rf_waddr", 64'(rf_waddr), 64'd17);
        chk("dir_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        chk("dir_rf_wen",   64'(rf_wen),   64'd1);

        // Stall: output full, commit not ready, then release
        step(4'b0011, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);
        step(4'b0000, 1'b1);

        // x0 write and a branch both complete without an RF write
        ex_wen[0] = 1'b1; ex_waddr[0] = 5'd0;
        ex_wen[1] = 1'b0; ex_waddr[1] = 5'd7;
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        hold_fields = 0;

        // Reset with a completion stuck, then pipe 3 alone
        step(4'b0110, 1'b0);
        step(4'b0110, 1'b0);
        do_reset(1);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);

        // Pointer at 3 wraps to 0
        do_reset(1);
        step(4'b0100, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b0000, 1'b1);

        // Lone pipe back-to-back
        for (int c = 0; c < 3; c++) step(4'b0010, 1'b1);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1);
            step(N'($urandom), 1'($urandom_range(0, 9) < 7));
        end
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

        for (int i = 0; i < N; i++)
            if (n_grants[i] == 0) begin
                n_tests++; n_fail++;
                $display("FAIL coverage pipe %0d: got 0 grants expected >0", i);
            end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
